// File: rtl/wb_spram16_if.sv
// ---------------------------------------------------------------------------
// Module   : wb_spram16_if
// Purpose  : Wishbone bus bundle between the RAM arbiter and wb_spram16.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface wb_spram16_if #(
    parameter int WIDTH = 10
);
    logic             wb_cyc;
    logic             wb_we;
    logic [3:0]       wb_sel;
    logic [WIDTH-1:0] wb_adr;
    logic [31:0]      wb_dat;
    logic             wb_ack;
    logic [31:0]      wb_rdt;

    modport master (
        output wb_cyc, wb_we, wb_sel, wb_adr, wb_dat,
        input  wb_ack, wb_rdt
    );

    modport slave (
        input  wb_cyc, wb_we, wb_sel, wb_adr, wb_dat,
        output wb_ack, wb_rdt
    );
endinterface

`default_nettype wire

// File: rtl/wb_spram16.sv
// ---------------------------------------------------------------------------
// Module   : wb_spram16
// Purpose  : Wishbone slave splitting 32-bit accesses into two halfword SPRAM
//            accesses (low half first) with single-cycle ack.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_spram16 #(
    parameter int WIDTH = 10
) (
    input  wire logic         wb_clk,
    input  wire logic         wb_rst_n,
    wb_spram16_if.slave       bus,
    output logic              m_en,
    output logic              m_we,
    output logic [3:0]        m_mask,
    output logic [WIDTH:0]    m_adr,
    output logic [15:0]       m_wdat,
    input  wire logic [15:0]  m_rdat
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_RD   = 3'd3,
        S_ACK  = 3'd4
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] adr_q;
    logic [31:0]      dat_q;
    logic [3:0]       sel_q;
    logic             we_q;
    logic             cyc_q;
    logic [31:0]      rdt_q;

    // cyc_q tracks whether the master stayed in the cycle; it gates the ack only,
    // the memory sequence always runs to completion once started.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rdt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.wb_cyc) begin
                        adr_q   <= bus.wb_adr;
                        dat_q   <= bus.wb_dat;
                        sel_q   <= bus.wb_sel;
                        we_q    <= bus.wb_we;
                        cyc_q   <= 1'b1;
                        state_q <= S_LO;
                    end
                end
                S_LO: begin
                    if (!bus.wb_cyc) cyc_q <= 1'b0;
                    state_q <= S_HI;
                end
                S_HI: begin
                    if (!bus.wb_cyc) cyc_q <= 1'b0;
                    if (!we_q) rdt_q[15:0] <= m_rdat;
                    state_q <= we_q ? S_ACK : S_RD;
                end
                S_RD: begin
                    if (!bus.wb_cyc) cyc_q <= 1'b0;
                    rdt_q[31:16] <= m_rdat;
                    state_q      <= S_ACK;
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic       w_lo;
    logic       w_hi;
    logic [1:0] w_half_sel;

    assign w_lo       = (state_q == S_LO);
    assign w_hi       = (state_q == S_HI);
    assign w_half_sel = w_hi ? sel_q[3:2] : sel_q[1:0];

    // Mask pairs: [3:2] cover the low byte, [1:0] the high byte of the halfword.
    assign m_en   = (w_lo | w_hi) & (~we_q | (|w_half_sel));
    assign m_we   = m_en & we_q;
    assign m_adr  = (w_lo | w_hi) ? {adr_q, w_hi} : '0;
    assign m_wdat = m_en ? (w_hi ? dat_q[31:16] : dat_q[15:0]) : 16'h0000;
    assign m_mask = m_en ? {{2{w_half_sel[0]}}, {2{w_half_sel[1]}}} : 4'h0;

    assign bus.wb_ack = (state_q == S_ACK) & cyc_q;
    assign bus.wb_rdt = (bus.wb_ack & ~we_q) ? rdt_q : 32'h0;

endmodule

`default_nettype wire
